// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical register indices for rename.
// Hands out up to four free registers per cycle (all-or-nothing grant), takes
// back up to four stale registers per cycle from retire, and keeps a committed
// head so a remap/flush can rewind the speculative head in a single cycle.

// Per-slot ring index: base pointer plus the slot's compacted offset, wrapping
// naturally at the ring size (ring depth is a power of two).
module phys_free_list_lane #(
    parameter int LW = 7,
    parameter int CW = 3
) (
    input  logic [LW-1:0] base,
    input  logic [CW-1:0] ofs,
    output logic [LW-1:0] idx
);
    assign idx = base + LW'(ofs);
endmodule

module phys_free_list #(
    parameter int PREG_NUM   = 128,
    parameter int ARCH_NUM   = 32,
    parameter int LIST_DEPTH = 128,
    parameter int PW         = $clog2(PREG_NUM)
) (
    input  logic          Clk,
    input  logic          Rest,
    input  logic          ListStop,
    input  logic          ReMapping,
    input  logic [3:0]    AllocReq,
    output logic          AllocAble,
    output logic [PW-1:0] AllocPR1,
    output logic [PW-1:0] AllocPR2,
    output logic [PW-1:0] AllocPR3,
    output logic [PW-1:0] AllocPR4,
    input  logic [3:0]    ReleaseAble,
    input  logic [PW-1:0] ReleasePR1,
    input  logic [PW-1:0] ReleasePR2,
    input  logic [PW-1:0] ReleasePR3,
    input  logic [PW-1:0] ReleasePR4,
    input  logic [3:0]    CommitAble,
    output logic [PW:0]   FreeCount
);
    localparam int NUM_LANES = 4;
    localparam int LW        = $clog2(LIST_DEPTH);
    localparam int CW        = $clog2(NUM_LANES + 1);
    localparam int FREE_INIT = PREG_NUM - ARCH_NUM;

    logic [PW-1:0] list_q [LIST_DEPTH];
    logic [LW-1:0] spec_q, commit_q, tail_q;

    logic [NUM_LANES-1:0][CW-1:0] alloc_ofs, rel_ofs;
    logic [NUM_LANES-1:0][LW-1:0] alloc_idx, rel_idx;
    logic [NUM_LANES-1:0][PW-1:0] alloc_pr, rel_pr;
    logic [CW-1:0]                alloc_n, rel_n, com_n;
    logic [LW-1:0]                free_ptr;

    assign rel_pr = {ReleasePR4, ReleasePR3, ReleasePR2, ReleasePR1};

    // Exclusive prefix counts give each slot its compacted offset; the final
    // running sums are the per-cycle pointer advances.
    always_comb begin
        alloc_n   = '0;
        rel_n     = '0;
        com_n     = '0;
        alloc_ofs = '0;
        rel_ofs   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            alloc_ofs[k] = alloc_n;
            rel_ofs[k]   = rel_n;
            alloc_n      = alloc_n + CW'(AllocReq[k]);
            rel_n        = rel_n + CW'(ReleaseAble[k]);
            com_n        = com_n + CW'(CommitAble[k]);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        phys_free_list_lane #(.LW(LW), .CW(CW)) u_alloc (
            .base (spec_q),
            .ofs  (alloc_ofs[k]),
            .idx  (alloc_idx[k])
        );
        phys_free_list_lane #(.LW(LW), .CW(CW)) u_rel (
            .base (tail_q),
            .ofs  (rel_ofs[k]),
            .idx  (rel_idx[k])
        );
        assign alloc_pr[k] = AllocReq[k] ? list_q[alloc_idx[k]] : '0;
    end

    // Free space comes from registered pointers only; a same-cycle release is
    // never visible to the same-cycle grant.
    assign free_ptr  = tail_q - spec_q;
    assign FreeCount = (PW + 1)'(free_ptr);
    assign AllocAble = !ListStop && !ReMapping && (free_ptr >= LW'(alloc_n));

    assign AllocPR1 = alloc_pr[0];
    assign AllocPR2 = alloc_pr[1];
    assign AllocPR3 = alloc_pr[2];
    assign AllocPR4 = alloc_pr[3];

    // Ring storage and pointers; freeze holds everything, recovery rewinds the
    // speculative head to the committed head including this cycle's commits.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < LIST_DEPTH; i++)
                list_q[i] <= (i < FREE_INIT) ? PW'(ARCH_NUM + i) : '0;
            spec_q   <= '0;
            commit_q <= '0;
            tail_q   <= LW'(FREE_INIT);
        end else if (!ListStop) begin
            for (int k = 0; k < NUM_LANES; k++)
                if (ReleaseAble[k]) list_q[rel_idx[k]] <= rel_pr[k];
            tail_q   <= tail_q + LW'(rel_n);
            commit_q <= commit_q + LW'(com_n);
            if (ReMapping)
                spec_q <= commit_q + LW'(com_n);
            else if (AllocAble)
                spec_q <= spec_q + LW'(alloc_n);
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: a behavioural ring model produces the
// expected outputs, which go through a scoreboard queue and are compared
// against the DUT with immediate assertions.
module tb_phys_free_list;
    logic       Clk = 1'b0;
    logic       Rest = 1'b1;
    logic       ListStop = 1'b0, ReMapping = 1'b0;
    logic [3:0] AllocReq = 4'b0, ReleaseAble = 4'b0, CommitAble = 4'b0;
    logic [6:0] ReleasePR1 = '0, ReleasePR2 = '0, ReleasePR3 = '0, ReleasePR4 = '0;
    logic       AllocAble;
    logic [6:0] AllocPR1, AllocPR2, AllocPR3, AllocPR4;
    logic [7:0] FreeCount;

    phys_free_list dut (
        .Clk(Clk), .Rest(Rest), .ListStop(ListStop), .ReMapping(ReMapping),
        .AllocReq(AllocReq), .AllocAble(AllocAble),
        .AllocPR1(AllocPR1), .AllocPR2(AllocPR2), .AllocPR3(AllocPR3), .AllocPR4(AllocPR4),
        .ReleaseAble(ReleaseAble),
        .ReleasePR1(ReleasePR1), .ReleasePR2(ReleasePR2),
        .ReleasePR3(ReleasePR3), .ReleasePR4(ReleasePR4),
        .CommitAble(CommitAble), .FreeCount(FreeCount)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb  [$];
    string       sbt [$];

    // behavioural model of the ring
    logic [6:0] m_list [128];
    logic [6:0] m_spec, m_commit, m_tail;

    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_list[i] = (i < 96) ? 7'(32 + i) : 7'd0;
        m_spec = 7'd0; m_commit = 7'd0; m_tail = 7'd96;
    endfunction

    function automatic logic [7:0] m_free();
        logic [6:0] d;
        d = m_tail - m_spec;
        return {1'b0, d};
    endfunction

    function automatic logic m_able();
        return !ListStop && !ReMapping && (m_free() >= 8'($countones(AllocReq)));
    endfunction

    function automatic logic [6:0] m_pr(input int k);
        int ofs;
        ofs = 0;
        for (int j = 0; j < k; j++) if (AllocReq[j]) ofs++;
        return AllocReq[k] ? m_list[7'(int'(m_spec) + ofs)] : 7'd0;
    endfunction

    function automatic logic [6:0] m_relpr(input int k);
        case (k)
            0: return ReleasePR1;
            1: return ReleasePR2;
            2: return ReleasePR3;
            default: return ReleasePR4;
        endcase
    endfunction

    function automatic void m_step();
        logic able;
        int an, rn, cn;
        if (ListStop) return;
        able = m_able();
        an = $countones(AllocReq);
        rn = $countones(ReleaseAble);
        cn = $countones(CommitAble);
        rn = 0;
        for (int k = 0; k < 4; k++)
            if (ReleaseAble[k]) begin
                m_list[7'(int'(m_tail) + rn)] = m_relpr(k);
                rn++;
            end
        if (ReMapping) m_spec = 7'(int'(m_commit) + cn);
        else if (able) m_spec = 7'(int'(m_spec) + an);
        m_tail   = 7'(int'(m_tail) + rn);
        m_commit = 7'(int'(m_commit) + cn);
    endfunction

    task automatic push_exp(input string t, input logic [31:0] v);
        sb.push_back(v);
        sbt.push_back(t);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] exp;
        string t;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected none", obs);
            return;
        end
        exp = sb.pop_front();
        t   = sbt.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", t, obs, exp);
        end
    endtask

    task automatic kchk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        push_exp(t, exp);
        chk(obs);
    endtask

    // Drive one cycle's inputs, queue the model's expectations, compare.
    task automatic drive_chk(input string nm, input logic [3:0] areq,
                             input logic [3:0] com = 4'b0, input logic remap = 1'b0,
                             input logic stop = 1'b0, input logic [3:0] rel = 4'b0,
                             input logic [6:0] p1 = 7'd0, input logic [6:0] p2 = 7'd0,
                             input logic [6:0] p3 = 7'd0, input logic [6:0] p4 = 7'd0);
        AllocReq = areq; CommitAble = com; ReMapping = remap; ListStop = stop;
        ReleaseAble = rel;
        ReleasePR1 = p1; ReleasePR2 = p2; ReleasePR3 = p3; ReleasePR4 = p4;
        push_exp({nm, ".able"}, 32'(m_able()));
        push_exp({nm, ".pr1"}, 32'(m_pr(0)));
        push_exp({nm, ".pr2"}, 32'(m_pr(1)));
        push_exp({nm, ".pr3"}, 32'(m_pr(2)));
        push_exp({nm, ".pr4"}, 32'(m_pr(3)));
        push_exp({nm, ".free"}, 32'(m_free()));
        #1;
        chk(32'(AllocAble));
        chk(32'(AllocPR1));
        chk(32'(AllocPR2));
        chk(32'(AllocPR3));
        chk(32'(AllocPR4));
        chk(32'(FreeCount));
    endtask

    task automatic tick();
        m_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [3:0] areq,
                       input logic [3:0] com = 4'b0, input logic remap = 1'b0,
                       input logic stop = 1'b0, input logic [3:0] rel = 4'b0,
                       input logic [6:0] p1 = 7'd0, input logic [6:0] p2 = 7'd0,
                       input logic [6:0] p3 = 7'd0, input logic [6:0] p4 = 7'd0);
        drive_chk(nm, areq, com, remap, stop, rel, p1, p2, p3, p4);
        tick();
    endtask

    // Async reset between clock edges, model follows immediately.
    task automatic mid_reset();
        Rest = 1'b0;
        #1;
        m_reset();
        Rest = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #1 Rest = 1'b0;
        // reset state, full-width grant 32..35
        drive_chk("rst4", 4'b1111);
        kchk("rst4.pr1_k", 32'(AllocPR1), 32);
        kchk("rst4.pr4_k", 32'(AllocPR4), 35);
        kchk("rst4.free_k", 32'(FreeCount), 96);
        Rest = 1'b1;
        tick();
        kchk("after4.free", 32'(FreeCount), 92);

        // sparse request compacts onto consecutive entries
        mid_reset();
        drive_chk("sparse", 4'b1010);
        kchk("sparse.pr2_k", 32'(AllocPR2), 32);
        kchk("sparse.pr4_k", 32'(AllocPR4), 33);
        kchk("sparse.pr1_k", 32'(AllocPR1), 0);
        tick();
        kchk("sparse.free_k", 32'(FreeCount), 94);

        // drain to two, then all-or-nothing refusal and exact fit
        for (int i = 0; i < 23; i++) cyc("drain", 4'b1111);
        kchk("drain.free_k", 32'(FreeCount), 2);
        drive_chk("over", 4'b0111);
        kchk("over.able_k", 32'(AllocAble), 0);
        tick();
        kchk("over.free_k", 32'(FreeCount), 2);
        cyc("fit", 4'b0011);
        kchk("fit.free_k", 32'(FreeCount), 0);
        cyc("empty1", 4'b0001);
        drive_chk("empty0", 4'b0000);
        kchk("empty0.able_k", 32'(AllocAble), 1);
        tick();

        // recovery: allocate 8, commit 3 (2 in the remap cycle), rewind
        mid_reset();
        cyc("rec_a", 4'b1111);
        cyc("rec_b", 4'b1111);
        kchk("rec.free88", 32'(FreeCount), 88);
        cyc("rec_c", 4'b0000, 4'b0001);
        cyc("rec_remap", 4'b1111, 4'b0011, 1'b1);
        drive_chk("rec_after", 4'b0001);
        kchk("rec.free93", 32'(FreeCount), 93);
        kchk("rec.pr1_35", 32'(AllocPR1), 35);
        tick();

        // move tail to 127: allocate, commit, then release 31 stale entries
        for (int i = 0; i < 9; i++) cyc("mv_alloc", 4'b1111);
        for (int i = 0; i < 9; i++) cyc("mv_commit", 4'b0000, 4'b1111);
        for (int b = 0; b < 8; b++)
            cyc("mv_rel", 4'b0000, 4'b0000, 1'b0, 1'b0, (b == 7) ? 4'b0111 : 4'b1111,
                7'(4 * b), 7'(4 * b + 1), 7'(4 * b + 2), 7'(4 * b + 3));
        kchk("mv.free87", 32'(FreeCount), 87);

        // release across the wrap: 5 -> List[127], 9 -> List[0]
        cyc("wrap_rel", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0101,
            7'd5, 7'd77, 7'd9, 7'd88);
        kchk("wrap.free89", 32'(FreeCount), 89);
        for (int i = 0; i < 21; i++) cyc("wrap_alloc", 4'b1111);
        cyc("wrap_alloc3", 4'b0111);
        kchk("wrap.free2", 32'(FreeCount), 2);

        // freeze overrides allocate, release and commit
        cyc("stop", 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111, 7'd40, 7'd41, 7'd42, 7'd43);
        kchk("stop.free2", 32'(FreeCount), 2);
        drive_chk("wrap_read", 4'b0011);
        kchk("wrap_read.pr1", 32'(AllocPR1), 5);
        kchk("wrap_read.pr2", 32'(AllocPR2), 9);
        tick();
        kchk("wrap_read.free0", 32'(FreeCount), 0);

        // asynchronous reset mid-cycle
        #2;
        AllocReq = 4'b0001;
        Rest = 1'b0;
        #1;
        kchk("async.free96", 32'(FreeCount), 96);
        kchk("async.pr1", 32'(AllocPR1), 32);
        kchk("async.able", 32'(AllocAble), 1);
        Rest = 1'b1;
        AllocReq = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
